sd_image_xfer_sched: RTL and testbench

//  Multi-slot SD image transfer sequencer between the SD FIFOs and the sd_ctrl_top sector interface.

---
 rtl/sd_image_xfer_sched.sv | 170 +++++++++++++++++
 tb/tb_sd_image_xfer_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_image_xfer_sched.sv
// Sector-by-sector SD image record/playback sequencer across NUM_SLOTS slot regions, in the SD clock domain.
// Start pulses are gated on FIFO level; each sector waits for sd_ctrl busy to rise and fall, with a timeout on the rise.
module sd_image_xfer_sched #(
  parameter int          SEC_WORDS     = 256,
  parameter int          IMG_SECTORS   = 2400,
  parameter int          NUM_SLOTS     = 4,
  parameter logic [31:0] BASE_ADDR     = 32'd16384,
  parameter int          WR_LEN_W      = 10,
  parameter int          RD_LEN_W      = 11,
  parameter int          RD_FIFO_DEPTH = 2048,
  parameter int          TIMEOUT_CYC   = 65535,
  localparam int         SLOT_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                SD_clk_ref,
  input  logic                sys_rst_n,
  input  logic                sd_init_done,
  input  logic                save_req,
  input  logic                read_req,
  input  logic                abort_req,
  input  logic [SLOT_W-1:0]   slot_sel,
  input  logic [WR_LEN_W-1:0] wr_fifo_len,
  input  logic [RD_LEN_W-1:0] rd_fifo_len,
  input  logic                wr_busy,
  input  logic                rd_busy,
  input  logic                wr_val_en,
  input  logic                rd_val_en,
  output logic                wr_start_en,
  output logic [31:0]         wr_sec_addr,
  output logic                rd_start_en,
  output logic [31:0]         rd_sec_addr,
  output logic                xfer_busy,
  output logic                save_done,
  output logic                read_done,
  output logic                aborted,
  output logic                err_timeout,
  output logic                err_wordcnt,
  output logic [15:0]         sec_idx
);
  localparam logic [3:0] IDLE = 4'd0, W_GATE = 4'd1, W_START = 4'd2, W_WAITHI = 4'd3, W_WAITLO = 4'd4,
                         R_GATE = 4'd5, R_START = 4'd6, R_WAITHI = 4'd7, R_WAITLO = 4'd8, FINISH = 4'd9;
  localparam logic [1:0] K_SAVE = 2'd0, K_READ = 2'd1, K_ABORT = 2'd2;
  localparam int WW = WR_LEN_W + 1;
  localparam int RW = RD_LEN_W + 1;
  localparam logic [WW-1:0] SEC_WL   = WW'(SEC_WORDS);
  localparam logic [RW-1:0] SEC_RL   = RW'(SEC_WORDS);
  localparam logic [RW-1:0] DEPTH_L  = RW'(RD_FIFO_DEPTH);
  localparam logic [15:0]   LAST_SEC = 16'(IMG_SECTORS - 1);
  localparam logic [15:0]   SEC_W16  = 16'(SEC_WORDS);
  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_CYC - 1);

  logic [3:0]        state;
  logic [1:0]        fin_kind;
  logic              is_wr, save_q, read_q, pend_save, pend_read, abort_lat;
  logic [SLOT_W-1:0] slot;
  logic [31:0]       tcnt, addr_nxt;
  logic [15:0]       wcnt, wcnt_nxt;
  logic [RW-1:0]     rd_len_x, rd_free;
  logic              save_edge, read_edge, wr_ok, rd_ok, val, busy_in;

  assign save_edge = sd_init_done & save_req & ~save_q;
  assign read_edge = sd_init_done & read_req & ~read_q;
  assign wr_ok     = {1'b0, wr_fifo_len} >= SEC_WL;
  assign rd_len_x  = {1'b0, rd_fifo_len};
  // Free space clamps at zero if the FIFO ever reports more than its depth.
  assign rd_free   = (rd_len_x > DEPTH_L) ? '0 : (DEPTH_L - rd_len_x);
  assign rd_ok     = rd_free >= SEC_RL;
  assign val       = is_wr ? wr_val_en : rd_val_en;
  assign busy_in   = is_wr ? wr_busy : rd_busy;
  assign wcnt_nxt  = (val && wcnt != 16'hFFFF) ? wcnt + 16'd1 : wcnt;
  assign addr_nxt  = BASE_ADDR + 32'(slot) * 32'(IMG_SECTORS) + {16'd0, sec_idx};

  assign wr_start_en = (state == W_START);
  assign rd_start_en = (state == R_START);
  assign xfer_busy   = (state != IDLE);
  assign save_done   = (state == FINISH) && (fin_kind == K_SAVE);
  assign read_done   = (state == FINISH) && (fin_kind == K_READ);
  assign aborted     = (state == FINISH) && (fin_kind == K_ABORT);

  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      fin_kind    <= K_SAVE;
      is_wr       <= 1'b0;
      save_q      <= 1'b0;
      read_q      <= 1'b0;
      pend_save   <= 1'b0;
      pend_read   <= 1'b0;
      abort_lat   <= 1'b0;
      slot        <= '0;
      tcnt        <= '0;
      wcnt        <= '0;
      sec_idx     <= '0;
      wr_sec_addr <= '0;
      rd_sec_addr <= '0;
      err_timeout <= 1'b0;
      err_wordcnt <= 1'b0;
    end else begin
      save_q <= save_req;
      read_q <= read_req;
      if (state != IDLE) begin
        if (is_wr && read_edge) pend_read <= 1'b1;
        if (!is_wr && save_edge) pend_save <= 1'b1;
        if (abort_req) abort_lat <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (save_edge || pend_save) begin
            state     <= W_GATE;
            is_wr     <= 1'b1;
            slot      <= slot_sel;
            sec_idx   <= '0;
            pend_save <= 1'b0;
            if (read_edge) pend_read <= 1'b1;
          end else if (read_edge || pend_read) begin
            state     <= R_GATE;
            is_wr     <= 1'b0;
            slot      <= slot_sel;
            sec_idx   <= '0;
            pend_read <= 1'b0;
          end
        end
        W_GATE: if (wr_ok) begin
          wr_sec_addr <= addr_nxt;
          state       <= W_START;
        end
        R_GATE: if (rd_ok) begin
          rd_sec_addr <= addr_nxt;
          state       <= R_START;
        end
        W_START, R_START: begin
          tcnt  <= '0;
          wcnt  <= '0;
          state <= is_wr ? W_WAITHI : R_WAITHI;
        end
        W_WAITHI, R_WAITHI: begin
          if (busy_in) begin
            state <= is_wr ? W_WAITLO : R_WAITLO;
          end else if (tcnt == TO_LAST) begin
            err_timeout <= 1'b1;
            fin_kind    <= K_ABORT;
            state       <= FINISH;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        W_WAITLO, R_WAITLO: begin
          wcnt <= wcnt_nxt;
          if (!busy_in) begin
            if (wcnt_nxt != SEC_W16) err_wordcnt <= 1'b1;
            if (sec_idx == LAST_SEC) begin
              fin_kind <= is_wr ? K_SAVE : K_READ;
              state    <= FINISH;
            end else if (abort_lat) begin
              fin_kind <= K_ABORT;
              state    <= FINISH;
            end else begin
              sec_idx <= sec_idx + 16'd1;
              state   <= is_wr ? W_GATE : R_GATE;
            end
          end
        end
        FINISH: begin
          abort_lat <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_image_xfer_sched.sv
// Directed bench for sd_image_xfer_sched: a vector table of whole transfers plus hand sequences for
// FIFO gating, busy timeout, abort and mid-transfer reset, against a small sd_ctrl busy/word model.
module tb_sd_image_xfer_sched;
  logic        SD_clk_ref, sys_rst_n, sd_init_done, save_req, read_req, abort_req;
  logic [1:0]  slot_sel;
  logic [9:0]  wr_fifo_len;
  logic [10:0] rd_fifo_len;
  logic        wr_busy, rd_busy, wr_val_en, rd_val_en;
  logic        wr_start_en, rd_start_en, xfer_busy, save_done, read_done, aborted, err_timeout, err_wordcnt;
  logic [31:0] wr_sec_addr, rd_sec_addr;
  logic [15:0] sec_idx;

  sd_image_xfer_sched #(.IMG_SECTORS(4), .TIMEOUT_CYC(100)) dut (
    .SD_clk_ref(SD_clk_ref), .sys_rst_n(sys_rst_n), .sd_init_done(sd_init_done),
    .save_req(save_req), .read_req(read_req), .abort_req(abort_req), .slot_sel(slot_sel),
    .wr_fifo_len(wr_fifo_len), .rd_fifo_len(rd_fifo_len), .wr_busy(wr_busy), .rd_busy(rd_busy),
    .wr_val_en(wr_val_en), .rd_val_en(rd_val_en), .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr),
    .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .xfer_busy(xfer_busy), .save_done(save_done),
    .read_done(read_done), .aborted(aborted), .err_timeout(err_timeout), .err_wordcnt(err_wordcnt),
    .sec_idx(sec_idx)
  );

  initial begin
    SD_clk_ref = 1'b0;
    forever #5 SD_clk_ref = ~SD_clk_ref;
  end

  int n_tests = 0, n_fail = 0;
  int n_wr, n_rd, n_sdone, n_rdone, n_abort, cycle, t_sdone, t_first_rd;
  logic [31:0] first_wr, last_wr, first_rd, last_rd;
  int wsec, bad_sec;
  bit wr_model_en;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge SD_clk_ref);
  endtask

  task automatic clear_counts();
    n_wr = 0; n_rd = 0; n_sdone = 0; n_rdone = 0; n_abort = 0;
    t_sdone = 0; t_first_rd = 0; wsec = 0;
    first_wr = '0; last_wr = '0; first_rd = '0; last_rd = '0;
  endtask

  task automatic pulse_req(input logic s, input logic r);
    save_req = s; read_req = r;
    cyc(2);
    save_req = 1'b0; read_req = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int target, input int budget);
    int k = 0;
    while (!((n_sdone + n_rdone + n_abort) >= target && !xfer_busy) && k < budget) begin
      @(negedge SD_clk_ref);
      k++;
    end
    check(nm, 128'(k < budget), 128'(1));
  endtask

  task automatic wait_sec(input string nm, input logic [15:0] idx, input int budget);
    int k = 0;
    while (!(sec_idx == idx && wr_busy) && k < budget) begin
      @(negedge SD_clk_ref);
      k++;
    end
    check(nm, 128'(k < budget), 128'(1));
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr, xfer_busy, save_done,
                 read_done, aborted, err_timeout, err_wordcnt, sec_idx});
  endfunction

  // Monitor: counts start/done pulses and records addresses on the falling edge.
  initial begin
    cycle = 0;
    forever begin
      @(negedge SD_clk_ref);
      if (wr_start_en) begin
        if (n_wr == 0) first_wr = wr_sec_addr;
        last_wr = wr_sec_addr;
        n_wr++;
      end
      if (rd_start_en) begin
        if (n_rd == 0) begin first_rd = rd_sec_addr; t_first_rd = cycle; end
        last_rd = rd_sec_addr;
        n_rd++;
      end
      if (save_done) begin n_sdone++; t_sdone = cycle; end
      if (read_done) n_rdone++;
      if (aborted) n_abort++;
      cycle++;
    end
  end

  // sd_ctrl write model: busy rises ~10 cycles after start, then one word per cycle.
  initial begin
    wr_busy = 1'b0; wr_val_en = 1'b0;
    forever begin
      @(negedge SD_clk_ref);
      if (wr_start_en && wr_model_en) begin
        repeat (9) @(negedge SD_clk_ref);
        wr_busy = 1'b1;
        @(negedge SD_clk_ref);
        repeat ((wsec == bad_sec) ? 255 : 256) begin
          wr_val_en = 1'b1;
          @(negedge SD_clk_ref);
        end
        wr_val_en = 1'b0; wr_busy = 1'b0;
        wsec++;
      end
    end
  end

  initial begin
    rd_busy = 1'b0; rd_val_en = 1'b0;
    forever begin
      @(negedge SD_clk_ref);
      if (rd_start_en) begin
        repeat (9) @(negedge SD_clk_ref);
        rd_busy = 1'b1;
        @(negedge SD_clk_ref);
        repeat (256) begin
          rd_val_en = 1'b1;
          @(negedge SD_clk_ref);
        end
        rd_val_en = 1'b0; rd_busy = 1'b0;
      end
    end
  end

  typedef struct {
    logic        do_save, do_read;
    logic [1:0]  slot;
    int          bad;
    logic [31:0] exp_wr0, exp_rd0;
    int          exp_nwr, exp_nrd, exp_sd, exp_rdn;
    logic        exp_errwc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int k;
    vecs[0] = '{1'b1, 1'b0, 2'd2, -1, 32'd16392, 32'd0,     4, 0, 1, 0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'd1, -1, 32'd0,     32'd16388, 0, 4, 0, 1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 2'd3, -1, 32'd16396, 32'd16396, 4, 4, 1, 1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 1,  32'd16384, 32'd0,     4, 0, 1, 0, 1'b1};

    sys_rst_n = 1'b0; sd_init_done = 1'b0; save_req = 1'b0; read_req = 1'b0; abort_req = 1'b0;
    slot_sel = '0; wr_fifo_len = 10'd300; rd_fifo_len = '0; bad_sec = -1; wr_model_en = 1'b1;
    clear_counts();
    cyc(3);
    check("reset_outputs", all_outs(), '0);
    sys_rst_n = 1'b1;
    cyc(2);

    // A save edge before init is discarded, not queued.
    pulse_req(1'b1, 1'b0);
    sd_init_done = 1'b1;
    cyc(20);
    check("pre_init_ignored", {n_wr, 31'd0, xfer_busy}, '0);

    for (int i = 0; i < 4; i++) begin
      clear_counts();
      bad_sec  = vecs[i].bad;
      slot_sel = vecs[i].slot;
      pulse_req(vecs[i].do_save, vecs[i].do_read);
      wait_done($sformatf("v%0d_complete", i), vecs[i].exp_sd + vecs[i].exp_rdn, 5000);
      cyc(3);
      check($sformatf("v%0d_n_wr", i), n_wr, vecs[i].exp_nwr);
      check($sformatf("v%0d_n_rd", i), n_rd, vecs[i].exp_nrd);
      check($sformatf("v%0d_save_done", i), n_sdone, vecs[i].exp_sd);
      check($sformatf("v%0d_read_done", i), n_rdone, vecs[i].exp_rdn);
      check($sformatf("v%0d_aborted", i), n_abort, 0);
      check($sformatf("v%0d_err_wordcnt", i), err_wordcnt, vecs[i].exp_errwc);
      check($sformatf("v%0d_err_timeout", i), err_timeout, 1'b0);
      if (vecs[i].exp_nwr > 0) begin
        check($sformatf("v%0d_wr_addr_first", i), first_wr, vecs[i].exp_wr0);
        check($sformatf("v%0d_wr_addr_last", i), last_wr, vecs[i].exp_wr0 + 32'd3);
      end
      if (vecs[i].exp_nrd > 0) begin
        check($sformatf("v%0d_rd_addr_first", i), first_rd, vecs[i].exp_rd0);
        check($sformatf("v%0d_rd_addr_last", i), last_rd, vecs[i].exp_rd0 + 32'd3);
      end
      if (vecs[i].do_save && vecs[i].do_read)
        check($sformatf("v%0d_save_before_read", i), 128'(t_sdone < t_first_rd), 128'(1));
    end
    bad_sec = -1;

    // Read gating: 148 words free holds the start; 256 free releases it.
    clear_counts();
    slot_sel = 2'd0; rd_fifo_len = 11'd1900;
    pulse_req(1'b0, 1'b1);
    cyc(60);
    check("gate_hold_no_start", n_rd, 0);
    check("gate_hold_busy", xfer_busy, 1'b1);
    rd_fifo_len = 11'd1792;
    k = 0;
    while (!rd_start_en && k < 5) begin
      @(negedge SD_clk_ref);
      k++;
    end
    check("gate_release_latency", 128'(k <= 2), 128'(1));
    wait_done("gate_read_complete", 1, 5000);
    cyc(3);
    check("gate_read_done", n_rdone, 1);
    rd_fifo_len = '0;

    // Busy never rises: timeout after ~100 cycles in the wait state.
    clear_counts();
    wr_model_en = 1'b0;
    pulse_req(1'b1, 1'b0);
    k = 0;
    while (!wr_start_en && k < 50) begin
      @(negedge SD_clk_ref);
      k++;
    end
    check("to_start_seen", 128'(k < 50), 128'(1));
    k = 0;
    while (!err_timeout && k < 200) begin
      @(negedge SD_clk_ref);
      k++;
    end
    check("to_cycles", 128'(k >= 99 && k <= 102), 128'(1));
    cyc(3);
    check("to_aborted", n_abort, 1);
    check("to_no_save_done", n_sdone, 0);
    check("to_idle", xfer_busy, 1'b0);
    check("to_err_sticky", {err_timeout, err_wordcnt}, 2'b11);
    wr_model_en = 1'b1;

    // Abort during sector 2 stops after that sector.
    clear_counts();
    slot_sel = 2'd1;
    pulse_req(1'b1, 1'b0);
    wait_sec("ab_reach_sec2", 16'd2, 3000);
    abort_req = 1'b1;
    cyc(1);
    abort_req = 1'b0;
    wait_done("ab_complete", 1, 2000);
    cyc(3);
    check("ab_aborted", n_abort, 1);
    check("ab_no_save_done", n_sdone, 0);
    check("ab_n_wr", n_wr, 3);
    check("ab_last_addr", last_wr, 32'd16390);

    // Reset in the middle of sector 3 abandons the transfer and clears every output.
    clear_counts();
    slot_sel = 2'd0;
    pulse_req(1'b1, 1'b0);
    wait_sec("rst_reach_sec3", 16'd3, 4000);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", all_outs(), '0);
    cyc(300);
    check("rst_hold_outputs", all_outs(), '0);
    sys_rst_n = 1'b1;
    cyc(20);
    check("rst_no_done", {n_sdone, n_abort, 31'd0, xfer_busy}, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
